// File: rtl/shazam_pkg.sv
// rtl/shazam_pkg.sv - shared types, default widths and helpers for the spectral frame scheduler
package shazam_pkg;

  // Lifecycle of one FFT engine slot
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    BUSY    = 2'd2,
    RECOVER = 2'd3
  } slot_state_t;

  localparam int SAMPLE_W = 12;
  localparam int MAG_W    = 16;
  localparam int BIN_W    = 9;

  // Engine-index width; never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_slot.sv
// rtl/frame_slot.sv - per-engine slot: lifecycle FSM, fill counter, bin counter, latched seq
module frame_slot
  import shazam_pkg::*;
#(
  parameter int FRAME_LEN = 512,
  parameter int BIN_W     = shazam_pkg::BIN_W,
  parameter int SEQ_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample,
  input  logic             dispatch,
  input  logic             fft_done,
  input  logic             mag_valid,
  input  logic [SEQ_W-1:0] seq_in,
  output slot_state_t      state,
  output logic             write_enable,
  output logic             fft_reset,
  output logic [BIN_W:0]   bin,
  output logic [SEQ_W-1:0] seq
);

  localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCW-1:0] FILL_LAST = FCW'(FRAME_LEN - 1);

  // Samples already taken for the frame being filled
  logic [FCW-1:0] fill_cnt;

  // The dispatching sample is the first sample of the frame
  assign write_enable = sample && (dispatch || (state == FILL));

  // Slot lifecycle; fft_reset is registered so it is high exactly while in RECOVER
  always_ff @(posedge clk) begin
    if (reset || !start) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      fft_reset <= 1'b1;
    end else begin
      fft_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (dispatch) begin
            fill_cnt <= FCW'(1);
            state    <= (FRAME_LEN == 1) ? BUSY : FILL;
          end
        end
        FILL: begin
          if (sample) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_LAST) state <= BUSY;
          end
        end
        BUSY: begin
          if (fft_done) begin
            state     <= RECOVER;
            fft_reset <= 1'b1;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bin counter: cleared on frame start, counts every magnitude, saturates once past the last bin
  always_ff @(posedge clk) begin
    if (reset || !start) begin
      bin <= '0;
    end else if (dispatch) begin
      bin <= '0;
    end else if (mag_valid && !bin[BIN_W]) begin
      bin <= bin + 1'b1;
    end
  end

  // Sequence tag of the frame owned by this slot
  always_ff @(posedge clk) begin
    if (reset) begin
      seq <= '0;
    end else if (start && dispatch) begin
      seq <= seq_in;
    end
  end

endmodule

// File: rtl/spectral_frame_scheduler.sv
// rtl/spectral_frame_scheduler.sv - overlapping frame dispatch to FFT engines and magnitude merge
module spectral_frame_scheduler
  import shazam_pkg::*;
#(
  parameter int NUM_ENGINES = 3,
  parameter int SAMPLE_W    = shazam_pkg::SAMPLE_W,
  parameter int MAG_W       = shazam_pkg::MAG_W,
  parameter int FRAME_LEN   = 512,
  parameter int HOP         = 256,
  parameter int BIN_W       = shazam_pkg::BIN_W,
  parameter int SEQ_W       = 8,
  localparam int EW         = clog2_min1(NUM_ENGINES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [SAMPLE_W-1:0]          adc_data,
  input  logic                         adc_data_valid,
  output logic [SAMPLE_W-1:0]          fft_sample,
  output logic [NUM_ENGINES-1:0]       fft_write_active,
  output logic [NUM_ENGINES-1:0]       fft_reset,
  input  logic [NUM_ENGINES-1:0]       fft_done,
  input  logic [NUM_ENGINES*MAG_W-1:0] fft_mag,
  input  logic [NUM_ENGINES-1:0]       fft_mag_valid,
  output logic                         mag_valid,
  output logic [BIN_W+MAG_W-1:0]       mag_data,
  output logic [EW-1:0]                mag_engine,
  output logic                         frame_done,
  output logic [EW-1:0]                frame_done_engine,
  output logic [SEQ_W-1:0]             frame_done_seq,
  output logic                         overrun,
  output logic                         mag_collision
);

  localparam int HCW = (HOP > 1) ? $clog2(HOP) : 1;
  localparam logic [HCW-1:0] HOP_LAST  = HCW'(HOP - 1);
  localparam logic [EW-1:0]  SLOT_LAST = EW'(NUM_ENGINES - 1);

  logic [HCW-1:0]   hop_cnt;
  logic [EW-1:0]    next_slot;
  logic [SEQ_W-1:0] frame_seq;

  slot_state_t                slot_state [NUM_ENGINES];
  logic [BIN_W:0]             slot_bin   [NUM_ENGINES];
  logic [SEQ_W-1:0]           slot_seq   [NUM_ENGINES];
  logic [NUM_ENGINES-1:0]     slot_we;
  logic [NUM_ENGINES-1:0]     slot_rst;
  logic [NUM_ENGINES-1:0]     slot_dispatch;
  logic [NUM_ENGINES-1:0]     done_hit;

  logic strobe;
  logic attempt;
  logic target_idle;

  assign strobe      = start && adc_data_valid;
  assign attempt     = strobe && (hop_cnt == '0);
  assign target_idle = (slot_state[next_slot] == IDLE);

  // Only an idle target accepts the frame; RECOVER counts as occupied
  always_comb begin
    slot_dispatch = '0;
    if (attempt && target_idle) slot_dispatch[next_slot] = 1'b1;
  end

  for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_slot
    assign done_hit[k] = start && fft_done[k] && (slot_state[k] == BUSY);

    frame_slot #(
      .FRAME_LEN (FRAME_LEN),
      .BIN_W     (BIN_W),
      .SEQ_W     (SEQ_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .sample       (strobe),
      .dispatch     (slot_dispatch[k]),
      .fft_done     (fft_done[k]),
      .mag_valid    (fft_mag_valid[k]),
      .seq_in       (frame_seq),
      .state        (slot_state[k]),
      .write_enable (slot_we[k]),
      .fft_reset    (slot_rst[k]),
      .bin          (slot_bin[k]),
      .seq          (slot_seq[k])
    );
  end

  assign fft_reset = slot_rst;

  // Hop counter, round-robin pointer, sequence numbering and the overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      hop_cnt   <= '0;
      next_slot <= '0;
      frame_seq <= '0;
      overrun   <= 1'b0;
    end else if (!start) begin
      hop_cnt   <= '0;
      next_slot <= '0;
    end else begin
      if (strobe) hop_cnt <= (hop_cnt == HOP_LAST) ? '0 : hop_cnt + 1'b1;
      if (attempt) begin
        next_slot <= (next_slot == SLOT_LAST) ? '0 : next_slot + 1'b1;
        frame_seq <= frame_seq + 1'b1;
        if (!target_idle) overrun <= 1'b1;
      end
    end
  end

  // Shared sample bus and per-engine write strobes, one cycle behind the ADC
  always_ff @(posedge clk) begin
    if (reset) begin
      fft_sample       <= '0;
      fft_write_active <= '0;
    end else begin
      fft_sample       <= adc_data;
      fft_write_active <= slot_we;
    end
  end

  logic          done_any;
  logic [EW-1:0] done_idx;

  // Lowest-index accepted fft_done is reported when several land together
  always_comb begin
    done_any = 1'b0;
    done_idx = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      if (done_hit[k]) begin
        done_any = 1'b1;
        done_idx = EW'(k);
      end
    end
  end

  // Frame-done pulse with engine and sequence tags
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done        <= 1'b0;
      frame_done_engine <= '0;
      frame_done_seq    <= '0;
    end else begin
      frame_done <= done_any;
      if (done_any) begin
        frame_done_engine <= done_idx;
        frame_done_seq    <= slot_seq[done_idx];
      end
    end
  end

  logic             win_any;
  logic [EW-1:0]    win_idx;
  logic [BIN_W:0]   win_bin;
  logic [MAG_W-1:0] win_mag;
  logic             multi_valid;

  // Merge priority: lowest-index valid engine wins
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      if (fft_mag_valid[k]) begin
        win_any = 1'b1;
        win_idx = EW'(k);
      end
    end
  end

  assign win_bin     = slot_bin[win_idx];
  assign win_mag     = fft_mag[int'(win_idx)*MAG_W +: MAG_W];
  assign multi_valid = |(fft_mag_valid & (fft_mag_valid - 1'b1));

  // Merged magnitude stream; bins past the forwarded range are swallowed
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_valid     <= 1'b0;
      mag_data      <= '0;
      mag_engine    <= '0;
      mag_collision <= 1'b0;
    end else begin
      mag_valid <= win_any && !win_bin[BIN_W];
      if (win_any && !win_bin[BIN_W]) begin
        mag_data   <= {win_bin[BIN_W-1:0], win_mag};
        mag_engine <= win_idx;
      end
      if (multi_valid) mag_collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spectral_frame_scheduler.sv
// tb/tb_spectral_frame_scheduler.sv - randomized and directed bench with a frame-level reference model
module tb_spectral_frame_scheduler;

  localparam int NE = 3;
  localparam int FL = 8;
  localparam int HP = 4;
  localparam int BW = 2;
  localparam int SW = 12;
  localparam int MW = 16;
  localparam int QW = 8;

  logic clk = 1'b0;
  logic reset, start, adc_data_valid;
  logic [SW-1:0]    adc_data;
  logic [SW-1:0]    fft_sample;
  logic [NE-1:0]    fft_write_active, fft_reset, fft_done, fft_mag_valid;
  logic [NE*MW-1:0] fft_mag;
  logic             mag_valid, frame_done, overrun, mag_collision;
  logic [BW+MW-1:0] mag_data;
  logic [1:0]       mag_engine, frame_done_engine;
  logic [QW-1:0]    frame_done_seq;

  always #5 clk = ~clk;

  spectral_frame_scheduler #(
    .NUM_ENGINES(NE), .SAMPLE_W(SW), .MAG_W(MW), .FRAME_LEN(FL),
    .HOP(HP), .BIN_W(BW), .SEQ_W(QW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .adc_data(adc_data), .adc_data_valid(adc_data_valid),
    .fft_sample(fft_sample), .fft_write_active(fft_write_active),
    .fft_reset(fft_reset), .fft_done(fft_done),
    .fft_mag(fft_mag), .fft_mag_valid(fft_mag_valid),
    .mag_valid(mag_valid), .mag_data(mag_data), .mag_engine(mag_engine),
    .frame_done(frame_done), .frame_done_engine(frame_done_engine),
    .frame_done_seq(frame_done_seq), .overrun(overrun), .mag_collision(mag_collision)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frames counted in strobed samples, engines as occupancy records
  int m_strobes, m_attempts, m_seq;
  int m_left [NE];
  bit m_wait [NE];
  bit m_recov[NE];
  int m_fseq [NE];
  int m_bins [NE];
  bit m_ovr, m_coll;
  bit auto_done[NE];

  logic [SW-1:0]    exp_sample;
  logic [NE-1:0]    exp_wa, exp_rst;
  logic             exp_fd, exp_mv, exp_ovr, exp_coll;
  logic [1:0]       exp_fd_eng, exp_me;
  logic [QW-1:0]    exp_fd_seq;
  logic [BW+MW-1:0] exp_md;

  int fd_eng_q[$];
  int fd_seq_q[$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; adc_data_valid = 1'b0; adc_data = '0;
    fft_done = '0; fft_mag_valid = '0; fft_mag = '0;
    m_strobes = 0; m_attempts = 0; m_seq = 0; m_ovr = 0; m_coll = 0;
    for (int k = 0; k < NE; k++) begin
      m_left[k] = 0; m_wait[k] = 0; m_recov[k] = 0; m_fseq[k] = 0; m_bins[k] = 0; auto_done[k] = 0;
    end
    exp_sample = '0; exp_wa = '0; exp_rst = '1; exp_fd = 0; exp_mv = 0; exp_ovr = 0; exp_coll = 0;
    fd_eng_q.delete(); fd_seq_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, sample outputs just after the edge
  task automatic cycle(input bit st, input bit v, input logic [SW-1:0] d,
                       input logic [NE-1:0] dn_in, input logic [NE-1:0] mv,
                       input logic [NE*MW-1:0] mags);
    logic [NE-1:0] dn;
    logic [BW-1:0] bin_lo;
    int disp, t, w, nv;
    @(negedge clk);
    dn = dn_in;
    for (int k = 0; k < NE; k++) if (auto_done[k] && m_wait[k]) dn[k] = 1'b1;
    start = st; adc_data_valid = v; adc_data = d;
    fft_done = dn; fft_mag_valid = mv; fft_mag = mags;

    disp = -1;
    exp_sample = d;
    exp_fd = 0;
    if (!st) begin
      m_strobes = 0; m_attempts = 0;
      for (int k = 0; k < NE; k++) begin m_left[k] = 0; m_wait[k] = 0; m_recov[k] = 0; end
      exp_rst = '1; exp_wa = '0;
    end else begin
      exp_rst = '0;
      for (int k = 0; k < NE; k++) begin
        if (m_wait[k] && dn[k]) begin
          exp_rst[k] = 1'b1;
          if (!exp_fd) begin exp_fd = 1; exp_fd_eng = 2'(k); exp_fd_seq = QW'(m_fseq[k]); end
        end
      end
      if (v && (m_strobes % HP == 0)) begin
        t = m_attempts % NE;
        if (m_left[t] == 0 && !m_wait[t] && !m_recov[t]) begin
          disp = t; m_fseq[t] = m_seq;
        end else begin
          m_ovr = 1;
        end
        m_attempts++;
        m_seq = (m_seq + 1) % 256;
      end
      exp_wa = '0;
      for (int k = 0; k < NE; k++) if (v && (m_left[k] > 0 || k == disp)) exp_wa[k] = 1'b1;
      for (int k = 0; k < NE; k++) begin
        if (m_wait[k] && dn[k]) begin m_wait[k] = 0; m_recov[k] = 1; end
        else m_recov[k] = 0;
        if (v && m_left[k] > 0) begin
          m_left[k]--;
          if (m_left[k] == 0) m_wait[k] = 1;
        end
        if (k == disp) m_left[k] = FL - 1;
      end
      if (v) m_strobes++;
    end

    w = -1; nv = 0;
    for (int k = 0; k < NE; k++) if (mv[k]) begin nv++; if (w < 0) w = k; end
    exp_mv = (w >= 0) && (m_bins[w] < (1 << BW));
    if (exp_mv) begin
      bin_lo = BW'(m_bins[w]);
      exp_md = {bin_lo, mags[w*MW +: MW]};
      exp_me = 2'(w);
    end
    if (nv > 1) m_coll = 1;
    for (int k = 0; k < NE; k++) begin
      if (!st || k == disp) m_bins[k] = 0;
      else if (mv[k]) m_bins[k]++;
    end
    exp_ovr = m_ovr; exp_coll = m_coll;

    @(posedge clk); #1;
    if (frame_done) begin fd_eng_q.push_back(int'(frame_done_engine)); fd_seq_q.push_back(int'(frame_done_seq)); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (fft_reset !== 3'b111) begin n_fail++; $display("FAIL reset_fft_reset: got %b expected 111", fft_reset); end
    n_checks++; if (fft_write_active !== 3'b000) begin n_fail++; $display("FAIL reset_write_active: got %b expected 000", fft_write_active); end
    n_checks++; if ({fft_sample, mag_valid, mag_data, mag_engine} !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%b/%h/%0d expected zeros", fft_sample, mag_valid, mag_data, mag_engine); end
    n_checks++; if ({frame_done, frame_done_engine, frame_done_seq, overrun, mag_collision} !== '0) begin n_fail++; $display("FAIL reset_flags: got %b/%0d/%0d/%b/%b expected zeros", frame_done, frame_done_engine, frame_done_seq, overrun, mag_collision); end
  endtask

  task automatic test_continuous();
    int exp_eng[4] = '{0, 1, 2, 0};
    do_reset();
    for (int k = 0; k < NE; k++) auto_done[k] = 1;
    for (int i = 0; i < 32; i++) begin
      cycle(1, 1, SW'(i), '0, '0, '0);
      n_checks++; if (fft_write_active !== exp_wa) begin n_fail++; $display("FAIL cont_write_active[%0d]: got %b expected %b", i, fft_write_active, exp_wa); end
      n_checks++; if (fft_sample !== SW'(i)) begin n_fail++; $display("FAIL cont_sample[%0d]: got %0d expected %0d", i, fft_sample, i); end
      if (i >= 4) begin
        n_checks++; if ($countones(fft_write_active) != 2) begin n_fail++; $display("FAIL cont_overlap[%0d]: got %b expected two bits", i, fft_write_active); end
      end
    end
    for (int i = 0; i < 4; i++) cycle(1, 0, '0, '0, '0, '0);
    n_checks++; if (fd_eng_q.size() < 4) begin n_fail++; $display("FAIL cont_done_count: got %0d expected >=4", fd_eng_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (fd_eng_q[i] != exp_eng[i] || fd_seq_q[i] != i) begin n_fail++; $display("FAIL cont_done_tag[%0d]: got eng %0d seq %0d expected eng %0d seq %0d", i, fd_eng_q[i], fd_seq_q[i], exp_eng[i], i); end
    end
  endtask

  task automatic test_overrun();
    int exp_eng[3] = '{1, 2, 1};
    int exp_seq[3] = '{1, 2, 4};
    do_reset();
    auto_done[1] = 1; auto_done[2] = 1;
    for (int i = 0; i < 24; i++) begin
      cycle(1, 1, SW'($urandom), '0, '0, '0);
      n_checks++; if (fft_write_active !== exp_wa) begin n_fail++; $display("FAIL ovr_write_active[%0d]: got %b expected %b", i, fft_write_active, exp_wa); end
      if (i == 11) begin
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b expected 0", overrun); end
      end
      if (i == 12) begin
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
      end
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, '0, '0, '0);
    n_checks++; if (fd_eng_q.size() != 3) begin n_fail++; $display("FAIL ovr_done_count: got %0d expected 3", fd_eng_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++; if (fd_eng_q[i] != exp_eng[i] || fd_seq_q[i] != exp_seq[i]) begin n_fail++; $display("FAIL ovr_done_tag[%0d]: got eng %0d seq %0d expected eng %0d seq %0d", i, fd_eng_q[i], fd_seq_q[i], exp_eng[i], exp_seq[i]); end
    end
  endtask

  task automatic test_gapped();
    int exp_eng[4] = '{0, 1, 2, 0};
    logic [SW-1:0] d;
    do_reset();
    for (int k = 0; k < NE; k++) auto_done[k] = 1;
    for (int c = 0; c < 72; c++) begin
      d = SW'($urandom);
      cycle(1, (c % 3) == 0, d, '0, '0, '0);
      n_checks++; if (fft_sample !== d) begin n_fail++; $display("FAIL gap_sample[%0d]: got %h expected %h", c, fft_sample, d); end
      n_checks++; if (fft_write_active !== exp_wa) begin n_fail++; $display("FAIL gap_write_active[%0d]: got %b expected %b", c, fft_write_active, exp_wa); end
    end
    for (int i = 0; i < 4; i++) cycle(1, 0, '0, '0, '0, '0);
    n_checks++; if (fd_eng_q.size() < 4) begin n_fail++; $display("FAIL gap_done_count: got %0d expected >=4", fd_eng_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (fd_eng_q[i] != exp_eng[i] || fd_seq_q[i] != i) begin n_fail++; $display("FAIL gap_done_tag[%0d]: got eng %0d seq %0d expected eng %0d seq %0d", i, fd_eng_q[i], fd_seq_q[i], exp_eng[i], i); end
    end
  endtask

  task automatic test_collision();
    do_reset();
    cycle(1, 0, '0, '0, '0, '0);
    n_checks++; if (mag_collision !== 1'b0) begin n_fail++; $display("FAIL coll_idle: got %b expected 0", mag_collision); end
    cycle(1, 0, '0, '0, 3'b110, {16'h0020, 16'h0010, 16'h0000});
    n_checks++; if ({mag_valid, mag_engine} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL coll_winner: got valid %b eng %0d expected valid 1 eng 1", mag_valid, mag_engine); end
    n_checks++; if (mag_data !== {2'd0, 16'h0010}) begin n_fail++; $display("FAIL coll_data: got %h expected %h", mag_data, {2'd0, 16'h0010}); end
    n_checks++; if (mag_collision !== 1'b1) begin n_fail++; $display("FAIL coll_flag: got %b expected 1", mag_collision); end
    cycle(1, 0, '0, '0, 3'b100, {16'h0030, 16'h0000, 16'h0000});
    n_checks++; if ({mag_valid, mag_engine, mag_data} !== {1'b1, 2'd2, 2'd1, 16'h0030}) begin n_fail++; $display("FAIL coll_next_bin: got %b/%0d/%h expected 1/2/%h", mag_valid, mag_engine, mag_data, {2'd1, 16'h0030}); end
    n_checks++; if (mag_collision !== 1'b1) begin n_fail++; $display("FAIL coll_sticky: got %b expected 1", mag_collision); end
  endtask

  task automatic test_restart();
    do_reset();
    for (int k = 0; k < NE; k++) auto_done[k] = 1;
    for (int i = 0; i < 6; i++) cycle(1, 1, SW'(i), '0, '0, '0);
    cycle(0, 1, '0, '0, '0, '0);
    n_checks++; if (fft_reset !== 3'b111) begin n_fail++; $display("FAIL restart_fft_reset: got %b expected 111", fft_reset); end
    n_checks++; if (fft_write_active !== 3'b000) begin n_fail++; $display("FAIL restart_write_idle: got %b expected 000", fft_write_active); end
    fd_eng_q.delete(); fd_seq_q.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, SW'(i), '0, '0, '0);
      if (i == 0) begin
        n_checks++; if (fft_write_active !== 3'b001) begin n_fail++; $display("FAIL restart_first: got %b expected 001", fft_write_active); end
      end
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, '0, '0, '0);
    n_checks++; if (fd_eng_q.size() < 1) begin n_fail++; $display("FAIL restart_done_count: got 0 expected >=1"); end
    else if (fd_eng_q[0] != 0 || fd_seq_q[0] != 2) begin n_fail++; $display("FAIL restart_done_tag: got eng %0d seq %0d expected eng 0 seq 2", fd_eng_q[0], fd_seq_q[0]); end
  endtask

  task automatic test_bin_limit();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, '0, '0, 3'b001, {32'h0, 16'(i + 1)});
      n_checks++; if (mag_valid !== (i < 4)) begin n_fail++; $display("FAIL bin_valid[%0d]: got %b expected %b", i, mag_valid, (i < 4)); end
      if (i < 4) begin
        n_checks++; if (mag_data !== {2'(i), 16'(i + 1)}) begin n_fail++; $display("FAIL bin_data[%0d]: got %h expected %h", i, mag_data, {2'(i), 16'(i + 1)}); end
      end
    end
  endtask

  task automatic test_random();
    logic [NE-1:0] dn, mv;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      dn = '0; mv = '0;
      for (int k = 0; k < NE; k++) begin
        dn[k] = ($urandom_range(0, 3) == 0);
        mv[k] = ($urandom_range(0, 2) == 0);
      end
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, SW'($urandom), dn, mv, (NE*MW)'({$urandom, $urandom}));
      n_checks++;
      if ({fft_sample, fft_write_active, fft_reset, frame_done, overrun, mag_collision, mag_valid} !==
          {exp_sample, exp_wa, exp_rst, exp_fd, exp_ovr, exp_coll, exp_mv}) begin
        n_fail++;
        $display("FAIL rand_outputs[%0d]: got smp %h wa %b rst %b fd %b ovr %b coll %b mv %b expected smp %h wa %b rst %b fd %b ovr %b coll %b mv %b",
                 c, fft_sample, fft_write_active, fft_reset, frame_done, overrun, mag_collision, mag_valid,
                 exp_sample, exp_wa, exp_rst, exp_fd, exp_ovr, exp_coll, exp_mv);
      end
      if (exp_fd) begin
        n_checks++; if ({frame_done_engine, frame_done_seq} !== {exp_fd_eng, exp_fd_seq}) begin n_fail++; $display("FAIL rand_done_tag[%0d]: got eng %0d seq %0d expected eng %0d seq %0d", c, frame_done_engine, frame_done_seq, exp_fd_eng, exp_fd_seq); end
      end
      if (exp_mv) begin
        n_checks++; if ({mag_engine, mag_data} !== {exp_me, exp_md}) begin n_fail++; $display("FAIL rand_mag[%0d]: got eng %0d data %h expected eng %0d data %h", c, mag_engine, mag_data, exp_me, exp_md); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; adc_data_valid = 1'b0; adc_data = '0;
    fft_done = '0; fft_mag_valid = '0; fft_mag = '0;
    test_reset();
    test_continuous();
    test_overrun();
    test_gapped();
    test_collision();
    test_restart();
    test_bin_limit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spectral_frame_scheduler.md
# spectral_frame_scheduler

- Parametrised front end between the ADC sample stream and a bank of NUM_ENGINES external FFT engines.
- Slices the stream into overlapping frames (FRAME_LEN samples, new frame every HOP samples) and dispatches them round-robin to the engines.
- Merges the engines' magnitude streams into one tagged stream with per-engine bin counters, and emits a frame-done pulse for the peak finder.
- Flags dispatch overruns and magnitude collisions instead of silently corrupting data.

## Interface

Parameters:
- NUM_ENGINES, 3, number of FFT engines (2..8)
- SAMPLE_W, 12, ADC sample width
- MAG_W, 16, engine magnitude width
- FRAME_LEN, 512, samples per frame (power of two)
- HOP, 256, samples between frame starts (1..FRAME_LEN)
- BIN_W, 9, bin index width; bins 0..2^BIN_W-1 are forwarded
- SEQ_W, 8, frame sequence number width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  run enable; low behaves as a soft reset of dispatch state
- adc_data  in  SAMPLE_W  sample
- adc_data_valid  in  1  sample strobe
- fft_sample  out  SAMPLE_W  registered adc_data, shared by all engines
- fft_write_active  out  NUM_ENGINES  per-engine sample strobe, aligned with fft_sample
- fft_reset  out  NUM_ENGINES  per-engine reset
- fft_done  in  NUM_ENGINES  engine finished emitting all magnitudes (1-cycle pulse)
- fft_mag  in  NUM_ENGINES*MAG_W  packed magnitudes, engine k at [k*MAG_W +: MAG_W]
- fft_mag_valid  in  NUM_ENGINES  magnitude strobes
- mag_valid  out  1  merged magnitude strobe
- mag_data  out  BIN_W+MAG_W  {bin, magnitude}
- mag_engine  out  $clog2(NUM_ENGINES)  source engine
- frame_done  out  1  pulse: the frame on frame_done_engine is complete
- frame_done_engine  out  $clog2(NUM_ENGINES)  engine that finished
- frame_done_seq  out  SEQ_W  sequence number of the finished frame
- overrun  out  1  sticky: a frame was dropped because its engine was busy
- mag_collision  out  1  sticky: two or more fft_mag_valid asserted in the same cycle

## Operation

- Each engine slot has four states: IDLE, FILL, BUSY, RECOVER.
  - IDLE -> FILL on dispatch.
  - FILL -> BUSY after FRAME_LEN strobed samples.
  - BUSY -> RECOVER on fft_done.
  - RECOVER -> IDLE after one cycle, with fft_reset[k] high during RECOVER.
- hop_cnt counts strobed samples modulo HOP. A dispatch occurs on a strobed sample with hop_cnt == 0. The first strobed sample after reset or start dispatches.
- The dispatch target is next_slot, which advances modulo NUM_ENGINES on every dispatch attempt, successful or not.
  - Target IDLE: the slot enters FILL, and this sample is its first sample. The slot latches frame_seq, then frame_seq increments (wraps at 2^SEQ_W).
  - Target not IDLE: the frame is dropped, overrun is set, and frame_seq still increments.
- fft_write_active[k] is high exactly when fft_sample carries a strobed sample that belongs to slot k's frame. Several bits may be high together (overlap).
- Merge: the lowest-index engine with fft_mag_valid wins. Each engine has its own bin counter.
  - The counter clears when the slot enters FILL and increments on each of that engine's valid magnitudes, including losing ones.
  - mag_valid is high only for bins < 2^BIN_W.
  - Losers are discarded, and mag_collision is set.
- frame_done: on fft_done[k], pulse with engine k and the seq latched by slot k.
- fft_done for a slot not in BUSY is ignored.
- start low: all slots are forced to IDLE, fft_reset is all ones, hop_cnt = 0, next_slot = 0. frame_seq and the sticky flags are kept.
- reset: same as start low, and also clears frame_seq, overrun and mag_collision.

## Timing

- Reset values:
  - fft_reset = all ones.
  - All other outputs are 0, including fft_sample, fft_write_active, mag_valid, mag_data, frame_done, overrun and mag_collision.
- fft_sample and fft_write_active are registered: one cycle after adc_data_valid.
- mag_valid, mag_data and mag_engine: one cycle after fft_mag_valid.
- frame_done and its tags: one cycle after fft_done. fft_reset[k] rises in the same cycle and is high for exactly one cycle.
- A slot in RECOVER cannot accept a dispatch in that cycle: the frame is dropped and overrun is set.
- fft_done in the same cycle as a dispatch to a different slot: both take effect.
- overrun and mag_collision assert one cycle after the causing event.

## Structure

- Package shazam_pkg holds:
  - the slot_state_t enum (IDLE/FILL/BUSY/RECOVER);
  - the default widths SAMPLE_W, MAG_W, BIN_W;
  - a function clog2_min1 for the engine-index width (1 when NUM_ENGINES is 2).
- One sub-module, frame_slot, instantiated NUM_ENGINES times. It holds:
  - the state register, fill counter, bin counter and latched seq;
  - dispatch and fft_done inputs;
  - outputs state, write_enable, fft_reset and bin.
- The top module holds hop_cnt, next_slot, frame_seq, the merge priority logic and the sticky flags.

## Test plan

All scenarios use NUM_ENGINES=3, FRAME_LEN=8, HOP=4 unless stated.

1. Continuous strobes, samples 0..31, engines respond with fft_done after their 8th sample.
   - Frames start at samples 0, 4, 8, 12… on engines 0, 1, 2, 0….
   - fft_write_active shows exactly two bits high after sample 4.
   - seq tags are 0, 1, 2, 3.
2. Engine 0 withholds fft_done.
   - The dispatch at sample 12 is dropped and overrun is set.
   - Engine 1 receives the sample-16 frame with seq 4.
3. Gapped strobes (valid every 3rd cycle).
   - Frame boundaries follow strobe count, not cycles.
   - fft_sample equals adc_data delayed by one cycle.
4. Engines 1 and 2 present magnitudes 0x0010 and 0x0020 in the same cycle.
   - Output: mag_engine = 1, mag_data = {0, 0x0010}, mag_collision = 1.
   - Engine 2's next magnitude carries bin 1.
5. start dropped mid-frame.
   - fft_reset = 3'b111 and all slots return to IDLE.
   - On re-start, the first sample dispatches to engine 0, with frame_seq continuing.
6. With BIN_W=2, an engine emits 6 magnitudes: only bins 0..3 produce mag_valid.
